// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: selects the writeback value (ALU result or an
// aligned, extended load), holds it behind a valid/ready handshake with a
// one-deep skid register, and presents it to the register file and the
// forwarding unit.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic [OFF_W-1:0]  in_byte_off,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [REG_AW-1:0] in_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [REG_AW-1:0] out_dst,
  output logic [DATA_W-1:0] out_wb_data,
  output logic              out_misaligned,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dst,
  output logic [DATA_W-1:0] fwd_data
);

  typedef enum logic [2:0] {
    LD_FULL  = 3'b000,
    LD_H     = 3'b001,
    LD_HU    = 3'b010,
    LD_B     = 3'b011,
    LD_BU    = 3'b100,
    LD_W     = 3'b101,
    LD_WU    = 3'b110,
    LD_FULL7 = 3'b111
  } loadType_t;

  typedef struct packed {
    logic              regWrite;
    logic [REG_AW-1:0] dst;
    logic [DATA_W-1:0] data;
    logic              misaligned;
  } entry_t;

  // Offsets rounded down to a halfword / word boundary inside the data word.
  localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

  logic [OFF_W+2:0]  byteShift;
  logic [OFF_W+2:0]  halfShift;
  logic [OFF_W+2:0]  wordShift;
  logic [7:0]        byteVal;
  logic [15:0]       halfVal;
  logic [31:0]       wordVal;
  logic [DATA_W-1:0] loadVal;
  logic              loadMis;
  entry_t            inEntry;

  entry_t oEntry;
  logic   oValid;
  entry_t sEntry;
  logic   sValid;

  logic xferIn;
  logic oDrain;

  // Build the incoming entry: lane-select and extend the load, pick the
  // writeback source, and flag offsets whose dropped low bits are nonzero.
  always_comb begin
    byteShift = {in_byte_off, 3'b000};
    halfShift = {in_byte_off & HALF_MASK, 3'b000};
    wordShift = {in_byte_off & WORD_MASK, 3'b000};
    byteVal   = 8'(in_read_data >> byteShift);
    halfVal   = 16'(in_read_data >> halfShift);
    wordVal   = 32'(in_read_data >> wordShift);
    loadVal   = in_read_data;
    loadMis   = |in_byte_off;
    case (loadType_t'(in_load_type))
      LD_H: begin
        loadVal = DATA_W'(signed'(halfVal));
        loadMis = in_byte_off[0];
      end
      LD_HU: begin
        loadVal = DATA_W'(halfVal);
        loadMis = in_byte_off[0];
      end
      LD_B: begin
        loadVal = DATA_W'(signed'(byteVal));
        loadMis = 1'b0;
      end
      LD_BU: begin
        loadVal = DATA_W'(byteVal);
        loadMis = 1'b0;
      end
      LD_W: begin
        loadVal = DATA_W'(signed'(wordVal));
        loadMis = |in_byte_off[1:0];
      end
      LD_WU: begin
        loadVal = DATA_W'(wordVal);
        loadMis = |in_byte_off[1:0];
      end
      default: begin
        loadVal = in_read_data;
        loadMis = |in_byte_off;
      end
    endcase
    inEntry.regWrite   = in_reg_write;
    inEntry.dst        = in_dst;
    inEntry.data       = in_mem_to_reg ? loadVal : in_alu_res;
    inEntry.misaligned = in_mem_to_reg & loadMis;
  end

  assign in_ready = ~sValid & ~reset;
  assign xferIn   = in_valid & in_ready;
  assign oDrain   = ~oValid | out_ready;

  // Output and skid registers: O refills from S first so order stays FIFO,
  // and S only captures an entry while O is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      oValid <= 1'b0;
      oEntry <= '0;
      sValid <= 1'b0;
      sEntry <= '0;
    end else if (flush) begin
      oValid <= 1'b0;
      sValid <= 1'b0;
    end else if (oDrain) begin
      if (sValid) begin
        oValid <= 1'b1;
        oEntry <= sEntry;
        sValid <= xferIn;
        if (xferIn) sEntry <= inEntry;
      end else begin
        oValid <= xferIn;
        if (xferIn) oEntry <= inEntry;
      end
    end else if (xferIn) begin
      sValid <= 1'b1;
      sEntry <= inEntry;
    end
  end

  assign out_valid      = oValid;
  assign out_dst        = oEntry.dst;
  assign out_wb_data    = oEntry.data;
  assign out_misaligned = oEntry.misaligned;
  assign out_reg_write  = oValid & oEntry.regWrite & (oEntry.dst != '0);

  assign fwd_valid = out_reg_write;
  assign fwd_dst   = oEntry.dst;
  assign fwd_data  = oEntry.data;

endmodule
